// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM
// states and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Ops 0..3 occupy the sequencer; moves and reserved codes do not.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the
// requested op and flags a zero divisor.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;

  // Division runs on magnitudes and re-applies signs, so 0x80000000 / -1
  // naturally yields 0x80000000 with remainder 0.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value held, which would otherwise infer a latch.
    hi        = '0;
    lo        = '0;
    div_zero  = 1'b0;
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    neg_a     = is_signed & a[31];
    neg_b     = is_signed & b[31];
    mag_a     = neg_a ? (~a + 32'd1) : a;
    mag_b     = neg_b ? (~b + 32'd1) : b;
    q_mag     = (mag_b == '0) ? '0 : (mag_a / mag_b);
    r_mag     = (mag_b == '0) ? '0 : (mag_a % mag_b);
    ext_a     = {{32{neg_a}}, a};
    ext_b     = {{32{neg_b}}, b};
    prod      = ext_a * ext_b;

    case (op)
      MD_MULT, MD_MULTU: begin
        hi = prod[63:32];
        lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        lo       = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        hi       = neg_a ? (~r_mag + 32'd1) : r_mag;
        div_zero = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide sequencer: owns HI/LO, runs mult/div over a fixed
// latency, performs MTHI/MTLO and raises the decode-stage stall.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_dz;
  logic [31:0]        ar_hi;
  logic [31:0]        ar_lo;
  logic               ar_dz;

  md_arith u_arith (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .hi       (ar_hi),
    .lo       (ar_lo),
    .div_zero (ar_dz)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_dz <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                res_hi <= ar_hi;
                res_lo <= ar_lo;
                res_dz <= ar_dz;
                cnt    <= (md_op == MD_DIV || md_op == MD_DIVU) ?
                          CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                state  <= MD_RUN;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          cnt <= cnt - CNT_W'(1);
          // A zero divisor burns the full latency but leaves HI/LO intact.
          if (cnt == CNT_W'(1)) begin
            if (!res_dz) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state == MD_RUN);
  assign stall = md_use_d & (busy | (start & md_is_arith(md_op)));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops
// checked against a 64-bit integer reference model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          checks;
  int          errors;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural result from plain 64-bit integer arithmetic.
  task automatic model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2: if (b != 0) begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
      3'd3: if (b != 0) begin exp_lo = 32'(ua / ub); exp_hi = 32'(ua % ub); end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input bit inject);
    int          n;
    logic [31:0] old_hi, old_lo;
    n        = (op >= 3'd2) ? DIV_N : MULT_N;
    start    = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    md_use_d = use_d;
    #1;
    check("stall_start", stall, use_d);
    check("busy_start", busy, 1'b0);
    step();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model_md(op, a, b);
    for (int k = 0; k < n; k++) begin
      check("busy_run", busy, 1'b1);
      check("stall_run", stall, use_d);
      check("hi_hold", hi, old_hi);
      check("lo_hold", lo, old_lo);
      if (inject && k == 1) begin
        start = 1'b1;
        md_op = 3'($urandom_range(0, 5));
      end
      step();
      start = 1'b0;
    end
    check("busy_done", busy, 1'b0);
    check("stall_done", stall, 1'b0);
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    start    = 1'b1;
    md_op    = op;
    rs_val   = v;
    md_use_d = 1'b1;
    #1;
    check("stall_mt", stall, 1'b0);
    step();
    start = 1'b0;
    model_md(op, v, 32'd0);
    check("busy_mt", busy, 1'b0);
    check("hi_mt", hi, exp_hi);
    check("lo_mt", lo, exp_lo);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    reset_n  = 1'b1;
    start    = 1'b0;
    md_op    = '0;
    rs_val   = '0;
    rt_val   = '0;
    md_use_d = 1'b0;
    #3 reset_n = 1'b0;
    #4;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", stall, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    run_md(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    run_md(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
    check("multu_hi_const", hi, 32'h0000_0002);
    check("multu_lo_const", lo, 32'hFFFF_FFFA);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run_md(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lo_const", lo, 32'd3);
    check("divu_hi_const", hi, 32'd1);

    mt(3'd4, 32'h0000_1234);
    mt(3'd5, 32'h0000_5678);
    run_md(3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    check("div0_hi_const", hi, 32'h0000_1234);
    check("div0_lo_const", lo, 32'h0000_5678);

    run_md(3'd0, 32'h0001_2345, 32'hFFFF_0010, 1'b1, 1'b1);

    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("ovf_lo_const", lo, 32'h8000_0000);
    check("ovf_hi_const", hi, 32'h0000_0000);
    run_md(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);

    // Reserved op leaves everything alone.
    start = 1'b1;
    md_op = 3'd6;
    rs_val = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    check("rsv_busy", busy, 1'b0);
    check("rsv_hi", hi, exp_hi);
    check("rsv_lo", lo, exp_lo);

    // Asynchronous reset mid-DIV, with cnt at 3.
    start    = 1'b1;
    md_op    = 3'd2;
    rs_val   = 32'd1000;
    rt_val   = 32'd7;
    md_use_d = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < DIV_N - 3; k++) step();
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_busy", busy, 1'b0);
    mt(3'd5, 32'h0000_ABCD);
    check("mtlo_const", lo, 32'h0000_ABCD);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      if (op <= 3'd3)
        run_md(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else
        mt(op, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It also performs single-cycle MTHI/MTLO writes and produces the stall request the hazard logic uses to hold any HI/LO-class instruction in decode while an operation is in flight. It sits beside the ALU in the EX stage and is driven by the decoded instruction type.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: EX-stage instruction is an md-class op; qualifies `md_op`.
- `md_op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `rs_val` input 32: forwarded rs operand, dividend or multiplicand.
- `rt_val` input 32: forwarded rt operand, divisor or multiplier.
- `md_use_d` input 1: decode-stage instruction reads or writes HI/LO (MULT*, DIV*, MFHI, MFLO, MTHI, MTLO).
- `busy` output 1: operation in flight.
- `stall` output 1: combinational; equals `md_use_d & (busy | (start & md_op<=3))`.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, RUN. `busy` = (state == RUN).
- IDLE with `start` and op 0–3:
  - Compute the result via `md_arith` from `rs_val`/`rt_val` sampled this cycle.
  - Latch it into `res_hi`/`res_lo` shadow registers.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt` goes 1→0, write `hi`←`res_hi` and `lo`←`res_lo`, then go to IDLE.
- MTHI/MTLO in IDLE: `hi`/`lo` ← `rs_val` on the next edge. No RUN entry, `busy` stays 0.
- `start` while in RUN: ignored. Operands are not sampled, counter and shadow registers are unchanged. Upstream stall guarantees this does not occur; the bench checks it anyway.
- Reserved `md_op` values: no state change.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned. `hi` = product[63:32], `lo` = product[31:0].
  - DIV: signed, quotient truncated toward zero, remainder takes the sign of the dividend. `lo` = quotient, `hi` = remainder.
  - DIVU: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): `lo` = 0x80000000, `hi` = 0.
  - Divisor 0 (DIV or DIVU): the full latency still elapses; `hi` and `lo` are left unchanged at completion.
- Reset (asynchronous, any state including mid-RUN):
  - State → IDLE, `cnt` → 0, `busy` → 0.
  - `hi` = `lo` = `res_hi` = `res_lo` = 0.
  - An in-flight result is discarded.

## Timing
- Operand sampling: on the edge ending the `start` cycle, call it edge E.
- `busy` is high for exactly N cycles after E (N = MULT_CYCLES or DIV_CYCLES). It falls on edge E+N, the same edge that updates `hi`/`lo`.
- MFHI/MFLO issued in the cycle after `busy` falls sees the new values.
- Back-to-back: a new `start` in the first cycle after `busy` falls is accepted.
- MTHI/MTLO: the new value is visible on `hi`/`lo` one cycle after the `start` cycle.
- `stall` has no register stage. It is high in the `start` cycle of a mult/div when `md_use_d`=1, and in every RUN cycle when `md_use_d`=1.

## Structure
- Shared package `md_pkg`: `md_op` encodings (MD_MULT … MD_MTLO), state enum (MD_IDLE, MD_RUN), defaults for MULT_CYCLES/DIV_CYCLES.
- Sub-module `md_arith`: purely combinational. Inputs are op, a, b; outputs are `{hi, lo}` and a `div_zero` flag. It keeps the behavioural `*`, `/` and `%` out of the FSM.
- `md_unit` contains the FSM, counter, shadow registers, HI/LO and stall logic.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1.
- DIV with divisor 0, preceded by MTHI 0x1234 and MTLO 0x5678 → `busy` high 10 cycles, then `hi`=0x1234 and `lo`=0x5678 unchanged.
- MULT followed by `md_use_d`=1 held → `stall` high in the start cycle and all 5 RUN cycles, low on the cycle `busy` falls. A second `start` injected mid-RUN leaves the result unchanged.
- `reset_n` pulsed low at cnt=3 of a DIV → `busy`, `hi`, `lo` go to 0 immediately. After release, MTLO 0xABCD → `lo`=0xABCD next cycle.
- 0x80000000 DIV 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Back-to-back MULT issued the cycle after completion is accepted.
